// File: rtl/posicionando_pecas_if.sv
`default_nettype none
// ============================================================================
// Module   : posicionando_pecas_if
// Purpose  : Button, board-feedback and placement-output bundle of the
//            piece placement controller.
// Revision : 1.0 - initial release
// ============================================================================
interface posicionando_pecas_if;
  logic       enable;
  logic       enter;
  logic       select;
  logic       mode;
  logic       conflito;
  logic       ready;
  logic       valida;
  logic [2:0] tipo;
  logic       jogador;
  logic [2:0] X1;
  logic [2:0] Y1;
  logic       direcao;
  logic       orientacao;

  modport master (
    output enable, enter, select, mode, conflito,
    input  ready, valida, tipo, jogador, X1, Y1, direcao, orientacao
  );

  modport slave (
    input  enable, enter, select, mode, conflito,
    output ready, valida, tipo, jogador, X1, Y1, direcao, orientacao
  );
endinterface
`default_nettype wire

// File: rtl/posicionando_pecas.sv
`default_nettype none
// ============================================================================
// Module   : posicionando_pecas
// Purpose  : Button-driven FSM that places each player's 11 ships on the board.
// Revision : 1.0 - initial release
// ============================================================================
module posicionando_pecas (
  input  wire                        clk,
  input  wire                        reset,
  posicionando_pecas_if.slave        bus
);

  typedef enum logic [2:0] {
    DIRECAO    = 3'd0,
    ORIENTACAO = 3'd1,
    DEF_X      = 3'd2,
    DEF_Y      = 3'd3,
    VERIFICA   = 3'd4,
    ARMAZENA   = 3'd5,
    DONE       = 3'd6
  } state_t;

  localparam logic [3:0] c_last_piece = 4'd10;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [2:0] r_tipo;
  logic       r_jogador;
  logic [2:0] r_x1;
  logic [2:0] r_y1;
  logic       r_direcao;
  logic       r_orientacao;
  logic       r_ready;
  logic       r_valida;
  logic       r_enter_s;
  logic       r_enter_p;
  logic       r_select_s;
  logic       r_select_p;

  logic       w_enter_fall;
  logic       w_select_fall;

  // Edge detection runs on the registered copy so the action is one clock
  // after the input register sees the press; a held button yields one edge.
  assign w_enter_fall  = r_enter_p & ~r_enter_s;
  assign w_select_fall = r_select_p & ~r_select_s;

  function automatic logic [2:0] f_tipo(input logic [3:0] n);
    logic [2:0] t;
    t = 3'd1;
    if (n >= 4'd10)     t = 3'd5;
    else if (n == 4'd9) t = 3'd4;
    else if (n >= 4'd7) t = 3'd3;
    else if (n >= 4'd5) t = 3'd2;
    return t;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= DIRECAO;
      r_cnt        <= 4'd0;
      r_tipo       <= 3'd1;
      r_jogador    <= 1'b0;
      r_x1         <= 3'd0;
      r_y1         <= 3'd0;
      r_direcao    <= 1'b0;
      r_orientacao <= 1'b0;
      r_ready      <= 1'b0;
      r_valida     <= 1'b0;
      r_enter_s    <= 1'b1;
      r_enter_p    <= 1'b1;
      r_select_s   <= 1'b1;
      r_select_p   <= 1'b1;
    end else begin
      // Button registers follow the pins even while disabled, so edges
      // seen during enable=0 are consumed rather than queued.
      r_enter_s  <= bus.enter;
      r_enter_p  <= r_enter_s;
      r_select_s <= bus.select;
      r_select_p <= r_select_s;
      r_valida   <= 1'b0;

      if (bus.enable) begin
        case (r_state)
          DIRECAO: begin
            if (w_enter_fall)       r_state   <= ORIENTACAO;
            else if (w_select_fall) r_direcao <= ~r_direcao;
          end
          ORIENTACAO: begin
            if (w_enter_fall)       r_state      <= DEF_X;
            else if (w_select_fall) r_orientacao <= ~r_orientacao;
          end
          DEF_X: begin
            if (w_enter_fall)       r_state <= DEF_Y;
            else if (w_select_fall) r_x1    <= r_x1 + 3'd1;
          end
          DEF_Y: begin
            if (w_enter_fall)       r_state <= VERIFICA;
            else if (w_select_fall) r_y1    <= r_y1 + 3'd1;
          end
          VERIFICA: begin
            if (w_enter_fall) begin
              if (bus.conflito) r_state <= DEF_X;
              else              r_state <= ARMAZENA;
            end
          end
          ARMAZENA: begin
            if (w_enter_fall) begin
              r_valida     <= 1'b1;
              r_x1         <= 3'd0;
              r_y1         <= 3'd0;
              r_direcao    <= 1'b0;
              r_orientacao <= 1'b0;
              if (r_cnt == c_last_piece) begin
                if (!r_jogador && !bus.mode) begin
                  r_jogador <= 1'b1;
                  r_cnt     <= 4'd0;
                  r_tipo    <= 3'd1;
                  r_state   <= DIRECAO;
                end else begin
                  r_ready   <= 1'b1;
                  r_state   <= DONE;
                end
              end else begin
                r_cnt   <= r_cnt + 4'd1;
                r_tipo  <= f_tipo(r_cnt + 4'd1);
                r_state <= DIRECAO;
              end
            end
          end
          DONE: begin
            r_ready <= 1'b1;
          end
          default: r_state <= DIRECAO;
        endcase
      end
    end
  end

  assign bus.ready      = r_ready;
  assign bus.valida     = r_valida;
  assign bus.tipo       = r_tipo;
  assign bus.jogador    = r_jogador;
  assign bus.X1         = r_x1;
  assign bus.Y1         = r_y1;
  assign bus.direcao    = r_direcao;
  assign bus.orientacao = r_orientacao;

endmodule
`default_nettype wire

// File: tb/tb_posicionando_pecas.sv
`default_nettype none
// ============================================================================
// Module   : tb_posicionando_pecas
// Purpose  : Directed self-checking bench for the piece placement controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_posicionando_pecas;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   vcount = 0;
  int   exp_tipo [0:10] = '{1, 1, 1, 1, 1, 2, 2, 3, 3, 4, 5};

  posicionando_pecas_if bus ();

  posicionando_pecas dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // valida is a full-cycle strobe, so each pulse is seen at exactly one falling edge
  always @(negedge clk) if (bus.valida === 1'b1) vcount++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic press_enter();
    bus.enter = 1'b0; repeat (3) tick();
    bus.enter = 1'b1; repeat (3) tick();
  endtask

  task automatic press_select();
    bus.select = 1'b0; repeat (3) tick();
    bus.select = 1'b1; repeat (3) tick();
  endtask

  task automatic place_piece();
    repeat (6) press_enter();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0d want 0", bus.ready); end
    checks++; if (bus.valida !== 1'b0) begin errors++; $display("FAIL reset_valida got %0d want 0", bus.valida); end
    checks++; if (bus.tipo !== 3'd1) begin errors++; $display("FAIL reset_tipo got %0d want 1", bus.tipo); end
    checks++; if (bus.jogador !== 1'b0) begin errors++; $display("FAIL reset_jogador got %0d want 0", bus.jogador); end
    checks++; if ({bus.X1, bus.Y1} !== 6'd0) begin errors++; $display("FAIL reset_xy got %0d/%0d want 0/0", bus.X1, bus.Y1); end
    checks++; if ({bus.direcao, bus.orientacao} !== 2'b00) begin errors++; $display("FAIL reset_dir_ori got %0d/%0d want 0/0", bus.direcao, bus.orientacao); end
  endtask

  task automatic test_single_piece();
    int base;
    base = vcount;
    place_piece();
    checks++; if (vcount - base !== 1) begin errors++; $display("FAIL single_valida got %0d pulses want 1", vcount - base); end
    checks++; if (bus.tipo !== 3'd1) begin errors++; $display("FAIL single_tipo got %0d want 1", bus.tipo); end
    checks++; if ({bus.X1, bus.Y1} !== 6'd0) begin errors++; $display("FAIL single_xy got %0d/%0d want 0/0", bus.X1, bus.Y1); end
  endtask

  task automatic test_coords_conflict();
    int base;
    base = vcount;
    press_select();
    checks++; if (bus.direcao !== 1'b1) begin errors++; $display("FAIL dir_toggle got %0d want 1", bus.direcao); end
    press_enter();
    press_select();
    checks++; if (bus.orientacao !== 1'b1) begin errors++; $display("FAIL ori_toggle got %0d want 1", bus.orientacao); end
    press_enter();
    repeat (9) press_select();
    checks++; if (bus.X1 !== 3'd1) begin errors++; $display("FAIL x_wrap got %0d want 1", bus.X1); end
    press_enter();
    repeat (3) press_select();
    checks++; if (bus.Y1 !== 3'd3) begin errors++; $display("FAIL y_inc got %0d want 3", bus.Y1); end
    press_enter();
    press_select();
    checks++; if ({bus.X1, bus.Y1} !== {3'd1, 3'd3}) begin errors++; $display("FAIL verifica_select got %0d/%0d want 1/3", bus.X1, bus.Y1); end
    bus.conflito = 1'b1;
    press_enter();
    checks++; if ({bus.X1, bus.Y1} !== {3'd1, 3'd3}) begin errors++; $display("FAIL conflict_xy got %0d/%0d want 1/3", bus.X1, bus.Y1); end
    checks++; if (vcount - base !== 0) begin errors++; $display("FAIL conflict_valida got %0d pulses want 0", vcount - base); end
    press_select();
    checks++; if (bus.X1 !== 3'd2) begin errors++; $display("FAIL conflict_back_defx got X1=%0d want 2", bus.X1); end
    bus.conflito = 1'b0;
    repeat (3) press_enter();
    press_select();
    checks++; if ({bus.X1, bus.Y1} !== {3'd2, 3'd3}) begin errors++; $display("FAIL armazena_select got %0d/%0d want 2/3", bus.X1, bus.Y1); end
    press_enter();
    checks++; if (vcount - base !== 1) begin errors++; $display("FAIL conflict_store got %0d pulses want 1", vcount - base); end
    checks++; if ({bus.X1, bus.Y1, bus.direcao, bus.orientacao} !== 8'd0) begin errors++; $display("FAIL next_piece_clear got %0h want 0", {bus.X1, bus.Y1, bus.direcao, bus.orientacao}); end
  endtask

  task automatic test_simultaneous();
    bus.enter = 1'b0; bus.select = 1'b0; repeat (3) tick();
    bus.enter = 1'b1; bus.select = 1'b1; repeat (3) tick();
    press_select();
    checks++; if ({bus.direcao, bus.orientacao} !== 2'b01) begin errors++; $display("FAIL both_priority got dir/ori %0d/%0d want 0/1", bus.direcao, bus.orientacao); end
    repeat (5) press_enter();
  endtask

  task automatic test_hold();
    bus.enter = 1'b0; repeat (10) tick();
    bus.enter = 1'b1; repeat (3) tick();
    press_select();
    checks++; if ({bus.orientacao, bus.X1} !== {1'b1, 3'd0}) begin errors++; $display("FAIL hold_once got ori/X1 %0d/%0d want 1/0", bus.orientacao, bus.X1); end
    repeat (5) press_enter();
  endtask

  task automatic test_enable();
    bus.enable = 1'b0;
    press_select();
    press_enter();
    checks++; if (bus.direcao !== 1'b0) begin errors++; $display("FAIL disabled_select got %0d want 0", bus.direcao); end
    bus.enable = 1'b1;
    press_select();
    checks++; if ({bus.direcao, bus.orientacao} !== 2'b10) begin errors++; $display("FAIL enable_discard got dir/ori %0d/%0d want 1/0", bus.direcao, bus.orientacao); end
    bus.enable = 1'b0;
    bus.enter = 1'b0; repeat (3) tick();
    bus.enable = 1'b1; repeat (3) tick();
    bus.enter = 1'b1; repeat (3) tick();
    press_select();
    checks++; if ({bus.direcao, bus.orientacao} !== 2'b00) begin errors++; $display("FAIL held_across_enable got dir/ori %0d/%0d want 0/0", bus.direcao, bus.orientacao); end
    place_piece();
    checks++; if (bus.tipo !== 3'd2) begin errors++; $display("FAIL sixth_piece_tipo got %0d want 2", bus.tipo); end
  endtask

  task automatic test_pvp_sequence();
    int base;
    do_reset();
    bus.mode = 1'b0;
    base = vcount;
    for (int p = 0; p < 22; p++) begin
      checks++; if (bus.tipo !== 3'(exp_tipo[p % 11])) begin errors++; $display("FAIL seq_tipo piece %0d got %0d want %0d", p, bus.tipo, exp_tipo[p % 11]); end
      checks++; if (bus.jogador !== (p >= 11)) begin errors++; $display("FAIL seq_jogador piece %0d got %0d want %0d", p, bus.jogador, p >= 11); end
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL seq_ready_early piece %0d got %0d want 0", p, bus.ready); end
      place_piece();
    end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL pvp_ready got %0d want 1", bus.ready); end
    checks++; if (vcount - base !== 22) begin errors++; $display("FAIL pvp_valida got %0d pulses want 22", vcount - base); end
    press_select();
    press_enter();
    press_enter();
    checks++; if (vcount - base !== 22 || bus.ready !== 1'b1 || bus.X1 !== 3'd0) begin errors++; $display("FAIL done_absorb got pulses %0d ready %0d X1 %0d want 22/1/0", vcount - base, bus.ready, bus.X1); end
    do_reset();
    checks++; if ({bus.ready, bus.jogador, bus.tipo} !== {1'b0, 1'b0, 3'd1}) begin errors++; $display("FAIL reset_from_done got ready/jog/tipo %0d/%0d/%0d want 0/0/1", bus.ready, bus.jogador, bus.tipo); end
  endtask

  task automatic test_pvc();
    int base;
    do_reset();
    base = vcount;
    bus.mode = 1'b0;
    repeat (10) place_piece();
    bus.mode = 1'b1;
    place_piece();
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL pvc_ready got %0d want 1", bus.ready); end
    checks++; if (bus.jogador !== 1'b0) begin errors++; $display("FAIL pvc_jogador got %0d want 0", bus.jogador); end
    bus.mode = 1'b0;
    place_piece();
    press_select();
    checks++; if (vcount - base !== 11 || bus.ready !== 1'b1 || bus.direcao !== 1'b0) begin errors++; $display("FAIL pvc_absorb got pulses %0d ready %0d dir %0d want 11/1/0", vcount - base, bus.ready, bus.direcao); end
  endtask

  initial begin
    bus.enable   = 1'b1;
    bus.enter    = 1'b1;
    bus.select   = 1'b1;
    bus.mode     = 1'b0;
    bus.conflito = 1'b0;
    test_reset();
    test_single_piece();
    test_coords_conflict();
    test_simultaneous();
    test_hold();
    test_enable();
    test_pvp_sequence();
    test_pvc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/posicionando_pecas.md
POSICIONANDO_PECAS -- requirements
Module: posicionando_pecas

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 enable  in  1  1 = FSM runs; 0 = all state and outputs hold.
REQ-004 enter  in  1  active-low confirm button, idle 1.
REQ-005 select  in  1  active-low select button, idle 1.
REQ-006 mode  in  1  0 = player vs player; 1 = player vs computer.
REQ-007 conflito  in  1  1 = current piece overlaps or leaves the board; computed externally from the outputs.
REQ-008 ready  out  1  1 = all placements finished.
REQ-009 valida  out  1  one-clock strobe: the current piece is stored.
REQ-010 tipo  out  3  current piece type: 1 submarino, 2 cruzador, 3 hidroaviao, 4 encouracado, 5 porta-avioes.
REQ-011 jogador  out  1  player currently placing: 0 or 1.
REQ-012 X1  out  3  column of the anchor cell, 0..7.
REQ-013 Y1  out  3  row of the anchor cell, 0..7.
REQ-014 direcao  out  1  0 horizontal, 1 vertical.
REQ-015 orientacao  out  1  0 positive sense, 1 negative sense.

Function
REQ-016 enter and select SHALL each be registered and falling-edge detected (1->0). A press SHALL produce exactly one action, however long the button is held.
REQ-017 FSM states SHALL be DIRECAO, ORIENTACAO, DEF_X, DEF_Y, VERIFICA, ARMAZENA, DONE.
REQ-018 DIRECAO: a select press SHALL toggle direcao; an enter press SHALL go to ORIENTACAO.
REQ-019 ORIENTACAO: a select press SHALL toggle orientacao; an enter press SHALL go to DEF_X.
REQ-020 DEF_X: a select press SHALL increment X1 mod 8 (7 wraps to 0); an enter press SHALL go to DEF_Y.
REQ-021 DEF_Y: a select press SHALL increment Y1 mod 8; an enter press SHALL go to VERIFICA.
REQ-022 VERIFICA: on an enter press, conflito is sampled. If conflito=0 the FSM SHALL go to ARMAZENA. If conflito=1 it SHALL go to DEF_X with X1 and Y1 retained.
REQ-023 ARMAZENA: an enter press SHALL assert valida for that one clock and advance to the next piece.
REQ-024 Piece sequence per player (11 pieces): 5x tipo 1, then 2x tipo 2, then 2x tipo 3, then 1x tipo 4, then 1x tipo 5. An internal piece counter runs 0..10.
REQ-025 On entry to the next piece (same player), X1, Y1, direcao and orientacao SHALL clear to 0 and the state SHALL be DIRECAO.
REQ-026 After the 11th store with jogador=0:
  - mode=0: jogador SHALL become 1, the counter and tipo SHALL restart at the first submarino, and the state SHALL be DIRECAO.
  - mode=1: the FSM SHALL go to DONE.
REQ-027 After the 11th store with jogador=1, the FSM SHALL go to DONE.
REQ-028 DONE SHALL be absorbing until reset. In DONE, ready=1 and button presses have no effect.
REQ-029 select presses in VERIFICA and ARMAZENA SHALL be ignored.
REQ-030 If enter and select fall in the same clock, enter SHALL take priority and select SHALL be ignored.
REQ-031 While enable=0, button edges SHALL be discarded, not queued. The edge-detect registers still track the buttons, so a press held across the rise of enable SHALL NOT fire.
REQ-032 mode SHALL be sampled only at the 11th store of player 0.

Reset
REQ-033 reset=1 at a clock edge SHALL set state=DIRECAO and:
  - ready=0, valida=0
  - tipo=1, jogador=0
  - X1=0, Y1=0, direcao=0, orientacao=0
  - piece counter=0
  - edge-detect registers=1 (buttons idle)
REQ-034 Reset SHALL override enable and SHALL abort any placement in progress, including from DONE.

Verification
REQ-035 Reset, enable=1; press enter 6 times with no select and conflito=0 -> valida pulses once; tipo stays 1; counter=1; X1=Y1=0.
REQ-036 In DEF_X, press select 9 times then enter -> X1=1 (wrap after 7). In DEF_Y, press select 3 times -> Y1=3.
REQ-037 In VERIFICA with conflito=1, press enter -> state DEF_X, valida=0, X1/Y1 unchanged. Set conflito=0 and press enter, enter, enter, enter -> valida pulses.
REQ-038 mode=0, 22 conflict-free placements -> tipo sequence 1,1,1,1,1,2,2,3,3,4,5 twice; jogador 0->1 after the 11th store; ready=1 after the 22nd store.
REQ-039 mode=1, 11 placements -> ready=1, jogador stays 0, further presses have no effect.
REQ-040 Hold enter low for 10 clocks in DIRECAO -> exactly one transition, to ORIENTACAO. With enable=0, select presses -> direcao unchanged.
